// File: rtl/hazard_stall_if.sv
// Pipeline hazard/sequencing bus between the datapath (master) and the
// hazard/stall controller (slave). The master presents hazard-relevant
// fields of the ID, EX and MEM stages. The slave returns the register enables,
// the flushes and the statistics.
interface hazard_stall_if #(
  parameter int REG_W = 3,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] ID_RegRs;
  logic [REG_W-1:0] ID_RegRt;
  logic             ID_uses_Rt;
  logic             EX_MemRead;
  logic [REG_W-1:0] EX_RegRt;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;

  logic             PC_write;
  logic             IF_ID_write;
  logic             IF_ID_flush;
  logic             ID_EX_flush;
  logic             EX_MEM_hold;
  logic             pc_sel_branch;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output ID_RegRs, ID_RegRt, ID_uses_Rt, EX_MemRead, EX_RegRt,
           branch_taken, mem_req, mem_ready,
    input  PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, EX_MEM_hold,
           pc_sel_branch, mem_timeout, stall_count, flush_count
  );

  modport slave (
    input  ID_RegRs, ID_RegRt, ID_uses_Rt, EX_MemRead, EX_RegRt,
           branch_taken, mem_req, mem_ready,
    output PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, EX_MEM_hold,
           pc_sel_branch, mem_timeout, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller for the 5-stage, 8-register CPU.
// Resolves load-use hazards with a single bubble, freezes the back of the pipe
// while a data-memory access is outstanding, flushes on taken branches, and
// keeps saturating stall/flush statistics plus a sticky memory-timeout flag.
// Control outputs are combinational from state and inputs so the pipe reacts
// in the same cycle the condition appears.
module hazard_stall_controller #(
  parameter int REG_W       = 3,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_stall_if.slave bus
);

  localparam int WAIT_W     = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam bit TIMEOUT_EN = (MEM_TIMEOUT != 0);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
  logic              timeout_flag;

  logic pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_hold, pc_sel;
  logic freeze_start;   // RUN-state access that did not complete this cycle
  logic branch_fire;    // branch honoured (counted) this cycle
  logic load_use_hit;

  // r0 is hard-wired zero, so a load "into" r0 never creates a real dependency.
  assign load_use_hit = bus.EX_MemRead && (bus.EX_RegRt != {REG_W{1'b0}}) &&
                        ((bus.EX_RegRt == bus.ID_RegRs) ||
                         (bus.ID_uses_Rt && (bus.EX_RegRt == bus.ID_RegRt)));

  // Same-cycle control decode: memory freeze > branch flush > load-use stall.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch to hold the old value.
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_hold  = 1'b0;
    pc_sel       = 1'b0;
    freeze_start = 1'b0;
    branch_fire  = 1'b0;
    if (!rst_n) begin
      // Hold fetch and drain bubbles into the pipe while reset is asserted.
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          if (bus.mem_req && !bus.mem_ready) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            ex_mem_hold  = 1'b1;
            freeze_start = 1'b1;
          end else if (bus.branch_taken) begin
            // The ID instruction is discarded, so any load-use stall is moot.
            pc_sel      = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            branch_fire = 1'b1;
          end else if (load_use_hit) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
        MEM_WAIT: begin
          // Branch/load-use are ignored here; the held stages re-present them.
          if (!bus.mem_ready) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            ex_mem_hold = 1'b1;
          end
        end
        default: begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          ex_mem_hold = 1'b1;
        end
      endcase
    end
  end

  // Sequencing state, wait timer, sticky timeout and saturating statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      wait_cnt     <= '0;
      stall_cnt    <= '0;
      flush_cnt    <= '0;
      timeout_flag <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values regardless of statement order inside this block.
      if (!pc_write && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (branch_fire && (flush_cnt != {CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + CNT_W'(1);

      unique case (state)
        RUN: begin
          if (freeze_start) begin
            state    <= MEM_WAIT;
            wait_cnt <= WAIT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (bus.mem_ready) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (TIMEOUT_EN && (wait_cnt == WAIT_W'(MEM_TIMEOUT))) begin
            state        <= ERROR;
            timeout_flag <= 1'b1;
          end else if (wait_cnt != {WAIT_W{1'b1}}) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        default: state <= ERROR;  // only rst_n leaves ERROR
      endcase
    end
  end

  assign bus.PC_write      = pc_write;
  assign bus.IF_ID_write   = if_id_write;
  assign bus.IF_ID_flush   = if_id_flush;
  assign bus.ID_EX_flush   = id_ex_flush;
  assign bus.EX_MEM_hold   = ex_mem_hold;
  assign bus.pc_sel_branch = pc_sel;
  assign bus.mem_timeout   = timeout_flag;
  assign bus.stall_count   = stall_cnt;
  assign bus.flush_count   = flush_cnt;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller. Inputs change on the falling
// edge; combinational controls are sampled 1ns later, and registered values are
// sampled after the following rising edge. Narrow counters (CNT_W=4) and a short
// timeout (MEM_TIMEOUT=4) keep the saturation and timeout cases short.
module tb_hazard_stall_controller;

  localparam int REG_W = 3;
  localparam int CNT_W = 4;

  // Control vector order: PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush,
  // EX_MEM_hold, pc_sel_branch.
  localparam logic [5:0] C_DEF = 6'b110000;
  localparam logic [5:0] C_RST = 6'b001100;
  localparam logic [5:0] C_FRZ = 6'b000010;
  localparam logic [5:0] C_LU  = 6'b000100;
  localparam logic [5:0] C_BR  = 6'b111101;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  hazard_stall_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

  hazard_stall_controller #(.REG_W(REG_W), .CNT_W(CNT_W), .MEM_TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [5:0] ctrl;
  assign ctrl = {bus.PC_write, bus.IF_ID_write, bus.IF_ID_flush, bus.ID_EX_flush,
                 bus.EX_MEM_hold, bus.pc_sel_branch};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.ID_RegRs     = '0;
    bus.ID_RegRt     = '0;
    bus.ID_uses_Rt   = 1'b0;
    bus.EX_MemRead   = 1'b0;
    bus.EX_RegRt     = '0;
    bus.branch_taken = 1'b0;
    bus.mem_req      = 1'b0;
    bus.mem_ready    = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (ctrl !== C_RST) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected %b", ctrl, C_RST);
    end
    n_checks++;
    if ({bus.mem_timeout, bus.stall_count, bus.flush_count} !== 9'd0) begin
      n_fail++; $display("FAIL reset_state: got to=%b stall=%0d flush=%0d expected 0/0/0",
                         bus.mem_timeout, bus.stall_count, bus.flush_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (ctrl !== C_DEF) begin
      n_fail++; $display("FAIL reset_release_ctrl: got %b expected %b", ctrl, C_DEF);
    end
  endtask

  task automatic test_load_use();
    apply_reset();
    // Rs match.
    bus.EX_MemRead = 1'b1; bus.EX_RegRt = 3'd3; bus.ID_RegRs = 3'd3;
    #1;
    n_checks++;
    if (ctrl !== C_LU) begin
      n_fail++; $display("FAIL load_use_rs_ctrl: got %b expected %b", ctrl, C_LU);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++;
    if (bus.stall_count !== 4'd1 || ctrl !== C_DEF) begin
      n_fail++; $display("FAIL load_use_one_bubble: got stall=%0d ctrl=%b expected 1/%b",
                         bus.stall_count, ctrl, C_DEF);
    end
    // Rt match with ID_uses_Rt.
    @(negedge clk);
    bus.EX_MemRead = 1'b1; bus.EX_RegRt = 3'd6; bus.ID_RegRs = 3'd2;
    bus.ID_RegRt = 3'd6; bus.ID_uses_Rt = 1'b1;
    #1;
    n_checks++;
    if (ctrl !== C_LU) begin
      n_fail++; $display("FAIL load_use_rt_ctrl: got %b expected %b", ctrl, C_LU);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++;
    if (bus.stall_count !== 4'd2) begin
      n_fail++; $display("FAIL load_use_rt_count: got %0d expected 2", bus.stall_count);
    end
  endtask

  task automatic test_no_hazard();
    logic [5:0] vec [3];
    apply_reset();
    // {EX_MemRead, uses_Rt, EX_RegRt, ID_RegRs, ID_RegRt} as directed vectors.
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      case (i)
        0: begin bus.EX_MemRead = 1'b1; bus.EX_RegRt = 3'd0; bus.ID_RegRs = 3'd0; end
        1: begin bus.EX_MemRead = 1'b1; bus.EX_RegRt = 3'd5; bus.ID_RegRs = 3'd1;
                 bus.ID_RegRt = 3'd5; bus.ID_uses_Rt = 1'b0; end
        default: begin bus.EX_MemRead = 1'b0; bus.EX_RegRt = 3'd4; bus.ID_RegRs = 3'd4; end
      endcase
      #1;
      vec[i] = ctrl;
      n_checks++;
      if (vec[i] !== C_DEF) begin
        n_fail++; $display("FAIL no_hazard_%0d: got %b expected %b", i, vec[i], C_DEF);
      end
      @(negedge clk);
    end
    idle_inputs();
    #1;
    n_checks++;
    if (bus.stall_count !== 4'd0) begin
      n_fail++; $display("FAIL no_hazard_count: got %0d expected 0", bus.stall_count);
    end
  endtask

  task automatic test_mem_freeze();
    apply_reset();
    // Three not-ready cycles; a branch presented meanwhile must be ignored.
    for (int i = 0; i < 3; i++) begin
      bus.mem_req = 1'b1; bus.mem_ready = 1'b0; bus.branch_taken = 1'b1;
      bus.EX_MemRead = 1'b1; bus.EX_RegRt = 3'd2; bus.ID_RegRs = 3'd2;
      #1;
      n_checks++;
      if (ctrl !== C_FRZ) begin
        n_fail++; $display("FAIL mem_freeze_cycle_%0d: got %b expected %b", i, ctrl, C_FRZ);
      end
      @(negedge clk);
    end
    idle_inputs();
    bus.mem_req = 1'b1; bus.mem_ready = 1'b1;
    #1;
    n_checks++;
    if (ctrl !== C_DEF) begin
      n_fail++; $display("FAIL mem_release: got %b expected %b", ctrl, C_DEF);
    end
    @(negedge clk);
    idle_inputs();  // mem_ready=0: would freeze if still in MEM_WAIT
    #1;
    n_checks++;
    if (ctrl !== C_DEF || bus.stall_count !== 4'd3 || bus.flush_count !== 4'd0) begin
      n_fail++; $display("FAIL mem_after: got ctrl=%b stall=%0d flush=%0d expected %b/3/0",
                         ctrl, bus.stall_count, bus.flush_count, C_DEF);
    end
    // Access completing in the same cycle it is requested: no freeze.
    @(negedge clk);
    bus.mem_req = 1'b1; bus.mem_ready = 1'b1;
    #1;
    n_checks++;
    if (ctrl !== C_DEF) begin
      n_fail++; $display("FAIL mem_same_cycle: got %b expected %b", ctrl, C_DEF);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++;
    if (ctrl !== C_DEF || bus.stall_count !== 4'd3) begin
      n_fail++; $display("FAIL mem_same_cycle_after: got ctrl=%b stall=%0d expected %b/3",
                         ctrl, bus.stall_count, C_DEF);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
    // RUN freeze cycle plus MEM_WAIT with wait_cnt 1..4: not yet timed out.
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (ctrl !== C_FRZ || bus.mem_timeout !== 1'b0) begin
        n_fail++; $display("FAIL timeout_wait_%0d: got ctrl=%b to=%b expected %b/0",
                           i, ctrl, bus.mem_timeout, C_FRZ);
      end
      @(negedge clk);
    end
    #1;
    n_checks++;
    if (bus.mem_timeout !== 1'b1 || bus.stall_count !== 4'd5) begin
      n_fail++; $display("FAIL timeout_flag: got to=%b stall=%0d expected 1/5",
                         bus.mem_timeout, bus.stall_count);
    end
    // ERROR ignores mem_ready and everything else.
    bus.mem_req = 1'b0; bus.mem_ready = 1'b1; bus.branch_taken = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (ctrl !== C_FRZ || bus.mem_timeout !== 1'b1 || bus.flush_count !== 4'd0) begin
      n_fail++; $display("FAIL error_sticky: got ctrl=%b to=%b flush=%0d expected %b/1/0",
                         ctrl, bus.mem_timeout, bus.flush_count, C_FRZ);
    end
    apply_reset();
    #1;
    n_checks++;
    if (ctrl !== C_DEF || bus.mem_timeout !== 1'b0) begin
      n_fail++; $display("FAIL error_exit_reset: got ctrl=%b to=%b expected %b/0",
                         ctrl, bus.mem_timeout, C_DEF);
    end
  endtask

  task automatic test_branch();
    apply_reset();
    bus.branch_taken = 1'b1;
    bus.EX_MemRead = 1'b1; bus.EX_RegRt = 3'd3; bus.ID_RegRs = 3'd3;
    #1;
    n_checks++;
    if (ctrl !== C_BR) begin
      n_fail++; $display("FAIL branch_ctrl: got %b expected %b", ctrl, C_BR);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++;
    if (bus.flush_count !== 4'd1 || bus.stall_count !== 4'd0) begin
      n_fail++; $display("FAIL branch_counts: got flush=%0d stall=%0d expected 1/0",
                         bus.flush_count, bus.stall_count);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    bus.branch_taken = 1'b1;
    repeat (2) @(negedge clk);
    // Load-use immediately after the branches.
    idle_inputs();
    bus.EX_MemRead = 1'b1; bus.EX_RegRt = 3'd7; bus.ID_RegRs = 3'd7;
    #1;
    n_checks++;
    if (ctrl !== C_LU) begin
      n_fail++; $display("FAIL b2b_load_use: got %b expected %b", ctrl, C_LU);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++;
    if (bus.flush_count !== 4'd2 || bus.stall_count !== 4'd1) begin
      n_fail++; $display("FAIL b2b_counts: got flush=%0d stall=%0d expected 2/1",
                         bus.flush_count, bus.stall_count);
    end
  endtask

  task automatic test_reset_mid_wait();
    apply_reset();
    bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
    repeat (2) @(negedge clk);   // now in MEM_WAIT with wait_cnt=2, stall=2
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (ctrl !== C_RST || bus.stall_count !== 4'd0) begin
      n_fail++; $display("FAIL mid_wait_reset: got ctrl=%b stall=%0d expected %b/0",
                         ctrl, bus.stall_count, C_RST);
    end
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if (ctrl !== C_DEF || bus.stall_count !== 4'd0) begin
      n_fail++; $display("FAIL mid_wait_release: got ctrl=%b stall=%0d expected %b/0",
                         ctrl, bus.stall_count, C_DEF);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    bus.EX_MemRead = 1'b1; bus.EX_RegRt = 3'd1; bus.ID_RegRs = 3'd1;
    repeat (18) @(negedge clk);
    #1;
    n_checks++;
    if (bus.stall_count !== 4'hF) begin
      n_fail++; $display("FAIL stall_saturate: got %0d expected 15", bus.stall_count);
    end
    idle_inputs();
    bus.branch_taken = 1'b1;
    repeat (17) @(negedge clk);
    #1;
    n_checks++;
    if (bus.flush_count !== 4'hF || bus.stall_count !== 4'hF) begin
      n_fail++; $display("FAIL flush_saturate: got flush=%0d stall=%0d expected 15/15",
                         bus.flush_count, bus.stall_count);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    idle_inputs();
    test_reset();
    test_load_use();
    test_no_hazard();
    test_mem_freeze();
    test_timeout();
    test_branch();
    test_back_to_back();
    test_reset_mid_wait();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
